// File: rtl/wb_pkg.sv
// Shared widths and requester identities for the register-file write-back path.
package wb_pkg;
    localparam int XLEN         = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NREGS        = 32;
    localparam int NREQ_DEFAULT = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_QMU = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, priority pointer moves past the winner on advance.
module rr_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] idx;
    logic             found;
    int               pos;

    // ptr holds the first index to search; the scan wraps past NREQ-1 back to 0
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        pos   = 0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            idx = PTR_W'(pos);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter in front of the register file, with an optional pending-write
// scoreboard enabled by the WB_SCOREBOARD_EN macro (busy tied to 0 otherwise).
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NREQ*XLEN-1:0]       req_wd,
    output logic                       rf_we,
    output logic [REG_ADDR_W-1:0]      rf_rd,
    output logic [XLEN-1:0]            rf_wd,
    input  logic                       claim_valid,
    input  logic [REG_ADDR_W-1:0]      claim_rd,
    output logic [NREGS-1:0]           busy
);
    logic [NREQ-1:0]       grant;
    logic                  hs;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_wd;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (hs),
        .grant   (grant)
    );

    // Grants are suppressed while reset is held so nothing can be accepted then
    assign req_ready = grant & {NREQ{rst_n}};
    assign hs        = |(req_valid & req_ready);

    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_wd = req_wd[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 are consumed but never raise the write enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_rd <= '0;
            rf_wd <= '0;
        end else if (hs) begin
            rf_we <= (sel_rd != '0);
            rf_rd <= sel_rd;
            rf_wd <= sel_wd;
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NREGS-1:0] busy_next;

    // Clear first, then set, so a same-edge claim keeps the register pending
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_rd] = 1'b0;
        end
        if (claim_valid && (claim_rd != '0)) begin
            busy_next[claim_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
`else
    logic unused_claim;
    assign unused_claim = ^{claim_valid, claim_rd};
    assign busy         = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a reference model checked every cycle.
module tb_regfile_wb_arbiter;
    logic         clk;
    logic         rst_n;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [14:0]  req_rd;
    logic [95:0]  req_wd;
    logic         rf_we;
    logic [4:0]   rf_rd;
    logic [31:0]  rf_wd;
    logic         claim_valid;
    logic [4:0]   claim_rd;
    logic [31:0]  busy;

    int checks   = 0;
    int failures = 0;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_wd      (req_wd),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wd       (rf_wd),
        .claim_valid (claim_valid),
        .claim_rd    (claim_rd),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v,
                                 input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                                 input logic [31:0] wd0, input logic [31:0] wd1, input logic [31:0] wd2,
                                 input logic cv, input logic [4:0] crd);
        req_valid   = v;
        req_rd      = {rd2, rd1, rd0};
        req_wd      = {wd2, wd1, wd0};
        claim_valid = cv;
        claim_rd    = crd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: remember who won last, scan onward from the next requester
    function automatic logic [2:0] expGrant(input logic [2:0] v, input int last);
        logic [2:0] g;
        int j;
        g = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            j = (last + k) % 3;
            if (v[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic int winner(input logic [2:0] g);
        for (int k = 0; k < 3; k++) begin
            if (g[k]) return k;
        end
        return 0;
    endfunction

    function automatic logic [31:0] nextBusy(input logic [31:0] b, input logic we, input logic [4:0] rd,
                                             input logic cv, input logic [4:0] crd);
        logic [31:0] n;
        if (!SB) return 32'h0;
        n = b;
        if (we) n[rd] = 1'b0;
        if (cv && crd != 5'd0) n[crd] = 1'b1;
        n[0] = 1'b0;
        return n;
    endfunction

    int          m_last;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic [31:0] m_busy;
    logic [2:0]  m_grant;

    assign m_grant = expGrant(req_valid, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last <= 2;
            m_we   <= 1'b0;
            m_rd   <= 5'd0;
            m_wd   <= 32'd0;
            m_busy <= 32'd0;
        end else begin
            m_busy <= nextBusy(m_busy, m_we, m_rd, claim_valid, claim_rd);
            if (m_grant != 3'b000) begin
                m_last <= winner(m_grant);
                m_we   <= (req_rd[winner(m_grant)*5 +: 5] != 5'd0);
                m_rd   <= req_rd[winner(m_grant)*5 +: 5];
                m_wd   <= req_wd[winner(m_grant)*32 +: 32];
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("req_ready", 64'(req_ready), 64'(m_grant));
            checkOutput("rf_we", 64'(rf_we), 64'(m_we));
            if (m_we) begin
                checkOutput("rf_rd", 64'(rf_rd), 64'(m_rd));
                checkOutput("rf_wd", 64'(rf_wd), 64'(m_wd));
            end
            checkOutput("busy", 64'(busy), 64'(m_busy));
        end
    end

    // A requester left waiting must keep valid, rd and wd unchanged
    logic [2:0]  pend;
    logic [14:0] prev_rd;
    logic [95:0] prev_wd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    checkOutput("req_hold", {27'd0, req_valid[i], req_rd[i*5 +: 5], req_wd[i*32 +: 32]},
                                {27'd0, 1'b1, prev_rd[i*5 +: 5], prev_wd[i*32 +: 32]});
                end
            end
            pend    <= req_valid & ~req_ready;
            prev_rd <= req_rd;
            prev_wd <= req_wd;
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
        #2;
        checkOutput("reset_ready", 64'(req_ready), 64'h0);
        checkOutput("reset_we", 64'(rf_we), 64'h0);
        checkOutput("reset_rd", 64'(rf_rd), 64'h0);
        checkOutput("reset_wd", 64'(rf_wd), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Three requesters in order, one write per cycle
        @(negedge clk); checkOutput("a_ready0", 64'(req_ready), 64'h1);
        tick(); applyStimulus(3'b110, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
        @(negedge clk); checkOutput("a_ready1", 64'(req_ready), 64'h2);
        checkOutput("a_we1", 64'(rf_we), 64'h1);
        checkOutput("a_rd1", 64'(rf_rd), 64'd1);
        checkOutput("a_wd1", 64'(rf_wd), 64'hA);
        tick(); applyStimulus(3'b100, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
        @(negedge clk); checkOutput("a_ready2", 64'(req_ready), 64'h4);
        checkOutput("a_rd2", 64'(rf_rd), 64'd2);
        checkOutput("a_wd2", 64'(rf_wd), 64'hB);
        tick(); applyStimulus(3'b000, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0);
        @(negedge clk); checkOutput("a_we3", 64'(rf_we), 64'h1);
        checkOutput("a_rd3", 64'(rf_rd), 64'd3);
        checkOutput("a_wd3", 64'(rf_wd), 64'hC);
        tick();
        @(negedge clk); checkOutput("a_idle_we", 64'(rf_we), 64'h0);
        checkOutput("a_hold_rd", 64'(rf_rd), 64'd3);
        checkOutput("a_hold_wd", 64'(rf_wd), 64'hC);

        // Lone LSU request
        tick(); applyStimulus(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("b_ready", 64'(req_ready), 64'h2);
        tick(); applyStimulus(3'b000, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("b_we", 64'(rf_we), 64'h1);
        checkOutput("b_rd", 64'(rf_rd), 64'd5);
        checkOutput("b_wd", 64'(rf_wd), 64'hDEADBEEF);

        // x0 write is consumed silently but still moves priority on
        tick(); applyStimulus(3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("c_ready_x0", 64'(req_ready), 64'h1);
        tick(); applyStimulus(3'b011, 5'd4, 5'd6, 5'd0, 32'h44, 32'h66, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("c_we_x0", 64'(rf_we), 64'h0);
        checkOutput("c_tie_ready", 64'(req_ready), 64'h2);
        tick(); applyStimulus(3'b001, 5'd4, 5'd6, 5'd0, 32'h44, 32'h66, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("c_rd6", 64'(rf_rd), 64'd6);
        checkOutput("c_ready_alu", 64'(req_ready), 64'h1);
        tick(); applyStimulus(3'b000, 5'd4, 5'd6, 5'd0, 32'h44, 32'h66, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("c_rd4", 64'(rf_rd), 64'd4);

        // Claim and write to x7 on the same edge: the claim wins
        tick(); applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
        tick(); applyStimulus(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77, 1'b0, 5'd0);
        @(negedge clk); checkOutput("d_busy7", 64'(busy), SB ? 64'h80 : 64'h0);
        tick(); applyStimulus(3'b000, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77, 1'b1, 5'd7);
        @(negedge clk); checkOutput("d_we7", 64'(rf_rd), 64'd7);
        tick(); applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("d_set_wins", 64'(busy), SB ? 64'h80 : 64'h0);
        tick(); applyStimulus(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h78, 1'b0, 5'd0);
        tick(); applyStimulus(3'b000, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h78, 1'b0, 5'd0);
        tick();
        @(negedge clk); checkOutput("d_cleared", 64'(busy), 64'h0);
        tick(); applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0);
        tick(); applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9);
        @(negedge clk); checkOutput("d_claim_x0", 64'(busy), 64'h0);
        tick(); applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("d_busy9", 64'(busy), SB ? 64'h200 : 64'h0);
        tick(); applyStimulus(3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk); checkOutput("d_ready9", 64'(req_ready), 64'h1);
        tick(); applyStimulus(3'b000, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 5'd0);
        tick();
        @(negedge clk); checkOutput("d_busy9_clr", 64'(busy), 64'h0);

        // Reset pulse right after a handshake drops the pending write
        tick(); applyStimulus(3'b110, 5'd0, 5'd10, 5'd11, 32'h0, 32'hA0, 32'hB0, 1'b1, 5'd12);
        @(negedge clk); checkOutput("e_ready", 64'(req_ready), 64'h2);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("e_rst_ready", 64'(req_ready), 64'h0);
        checkOutput("e_rst_we", 64'(rf_we), 64'h0);
        checkOutput("e_rst_busy", 64'(busy), 64'h0);
        applyStimulus(3'b111, 5'd13, 5'd14, 5'd15, 32'hD, 32'hE, 32'hF, 1'b0, 5'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk); checkOutput("e_post_we", 64'(rf_we), 64'h0);
        checkOutput("e_post_busy", 64'(busy), 64'h0);
        checkOutput("e_post_ready", 64'(req_ready), 64'h1);
        tick(); applyStimulus(3'b110, 5'd13, 5'd14, 5'd15, 32'hD, 32'hE, 32'hF, 1'b0, 5'd0);
        @(negedge clk); checkOutput("e_rd13", 64'(rf_rd), 64'd13);
        tick(); applyStimulus(3'b100, 5'd13, 5'd14, 5'd15, 32'hD, 32'hE, 32'hF, 1'b0, 5'd0);
        tick(); applyStimulus(3'b000, 5'd13, 5'd14, 5'd15, 32'hD, 32'hE, 32'hF, 1'b0, 5'd0);
        @(negedge clk); checkOutput("e_rd15", 64'(rf_rd), 64'd15);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
